au_cmp_eq_seq: RTL and testbench
================================

// Module: au_cmp_eq_seq
// PURPOSE
//   Sequencer for a WIDTH-bit word equality comparator. Checks two long operands
//   that arrive as a stream of word pairs (valid/ready, last-flagged) and returns
//   one equal/not-equal verdict per operand. Sits between a word-serial operand
//   source and a result consumer. Lets a wide equality check reuse one
//   word-wide ~(a^b) reduction.
// PARAMETERS
//   WIDTH  8  word length of in_a/in_b (>= 1)
//   CNTW   8  width of beat counter out_cnt (>= 1); counts beats per operand
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   in_valid   in   1      word pair on in_a/in_b/in_last is valid
//   in_ready   out  1      block accepts a word pair this cycle
//   in_a       in   WIDTH  operand A word
//   in_b       in   WIDTH  operand B word
//   in_last    in   1      marks the final word pair of the operand
//   out_valid  out  1      verdict available
//   out_ready  in   1      consumer takes the verdict this cycle
//   out_eq     out  1      1 = every accepted word pair of the operand was equal
//   out_cnt    out  CNTW   number of word pairs in the operand (saturating)
//   out_idx    out  CNTW   first mismatching beat index (only with CMP_EQ_IDX_EN)
// BEHAVIOUR
//   - Beat accepted when in_valid && in_ready. Word compare: weq = &(~(in_a ^ in_b)).
//   - States:
//     - ACC (reset state): in_ready=1, out_valid=0.
//       On an accepted beat: eq_acc <= eq_acc & weq; cnt <= cnt+1, saturating at
//       all-ones (2^CNTW-1, no wrap).
//       If in_last is set on that beat: go to DONE, latch out_eq = eq_acc & weq and
//       out_cnt = saturated cnt+1.
//     - DONE: in_ready=0, out_valid=1. Outputs are held stable until out_ready.
//       On out_ready: go to ACC with eq_acc<=1 and cnt<=0.
//   - Latency: out_valid rises on the clock edge that accepts the last beat, so the
//     verdict is visible in the following cycle. There is one bubble cycle after a
//     handshake (in_ready=0 while in DONE).
//   - Combinational paths: none from in_* to out_*. in_ready depends only on state.
//   - Single-beat operand (in_last on first beat): out_cnt=1, out_eq=weq.
//   - Mismatch on an early beat: all further beats are still consumed until in_last.
//     There is no early exit, so stream alignment is kept.
//   - out_valid && !out_ready: the verdict is held and input is stalled. No verdict
//     is lost or overwritten.
//   - in_valid low mid-operand: state and accumulator hold. Gaps are allowed.
//   - Reset (asynchronous assert, any state, including mid-operand):
//     - state=ACC, eq_acc=1, cnt=0.
//     - out_valid=0, out_eq=0, out_cnt=0, out_idx=0, in_ready=1 one cycle after
//       release. While rst=1, in_ready=0.
//     - A partial operand is discarded.
// CONFIGURATION
//   CMP_EQ_IDX_EN defined:
//     - out_idx = 0-based index of the first beat with weq=0, latched once per
//       operand. Index counting saturates like cnt.
//     - If all words are equal, out_idx = out_cnt.
//     - out_idx is held with out_eq in DONE and cleared on return to ACC.
//   CMP_EQ_IDX_EN undefined:
//     - out_idx is tied to 0.
//     - No index register or first-mismatch flag is built.
// TESTING
//   1 Operand 4 beats, a=b={11,22,33,44}, last on beat 4 -> out_valid next cycle,
//     out_eq=1, out_cnt=4, out_idx=4 (IDX_EN).
//   2 Operand 3 beats, a={01,02,03}, b={01,F2,00} -> out_eq=0, out_cnt=3, out_idx=1
//     (IDX_EN) / 0 (no IDX_EN).
//   3 Back-to-back operands with out_ready held low 5 cycles -> in_ready=0 and
//     verdict stable for those 5 cycles. Second operand verdict is independent:
//     eq_acc restarts at 1.
//   4 CNTW=2, 6-beat all-equal operand -> out_cnt=3 (saturated), out_eq=1.
//   5 rst pulsed asynchronously after beat 2 of 4 (beat 1 mismatched) -> outputs
//     zero immediately. A following 1-beat a=b=5A gives out_eq=1, out_cnt=1.
//   6 Random in_valid/out_ready throttling, 1000 operands, lengths 1..16 ->
//     scoreboard matches the reference model on out_eq/out_cnt/out_idx; no lost or
//     duplicated verdicts.

Source files
------------

// File: rtl/au_cmp_eq_seq_if.sv
// Stream bundle for au_cmp_eq_seq: word-pair input stream and verdict output stream.
// master drives operands and consumes verdicts; slave is the comparator sequencer.
interface au_cmp_eq_seq_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_eq;
    logic [CNTW-1:0]  out_cnt;
    logic [CNTW-1:0]  out_idx;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_eq, out_cnt, out_idx
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_eq, out_cnt, out_idx
    );
endinterface

// File: rtl/au_cmp_eq_seq.sv
// Word-serial equality sequencer: folds per-word ~(a^b) reductions into one verdict per operand.
// Optional first-mismatch index output enabled by defining CMP_EQ_IDX_EN.
module au_cmp_eq_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 8
) (
    input logic             clk,
    input logic             rst,
    au_cmp_eq_seq_if.slave  bus
);
    localparam logic [CNTW-1:0] CntMax = '1;

    typedef enum logic {StAcc, StDone} state_e;

    state_e            r_state, w_state_nxt;
    logic              r_eq_acc, w_eq_acc_nxt;
    logic [CNTW-1:0]   r_cnt, w_cnt_nxt;
    logic              r_out_eq, w_out_eq_nxt;
    logic [CNTW-1:0]   r_out_cnt, w_out_cnt_nxt;

    logic              w_weq;
    logic              w_fire;
    logic              w_eq_now;
    logic [CNTW-1:0]   w_cnt_inc;

    assign w_weq     = &(~(bus.in_a ^ bus.in_b));
    assign w_fire    = bus.in_valid && bus.in_ready;
    assign w_eq_now  = r_eq_acc & w_weq;
    assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + CNTW'(1);

    // Held low during reset so no beat is taken while the block is being cleared.
    assign bus.in_ready  = (r_state == StAcc) && !rst;
    assign bus.out_valid = (r_state == StDone);
    assign bus.out_eq    = r_out_eq;
    assign bus.out_cnt   = r_out_cnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_eq_acc_nxt  = r_eq_acc;
        w_cnt_nxt     = r_cnt;
        w_out_eq_nxt  = r_out_eq;
        w_out_cnt_nxt = r_out_cnt;
        unique case (r_state)
            StAcc: begin
                if (w_fire) begin
                    w_eq_acc_nxt = w_eq_now;
                    w_cnt_nxt    = w_cnt_inc;
                    if (bus.in_last) begin
                        w_state_nxt   = StDone;
                        w_out_eq_nxt  = w_eq_now;
                        w_out_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_state_nxt   = StAcc;
                    w_eq_acc_nxt  = 1'b1;
                    w_cnt_nxt     = '0;
                    w_out_eq_nxt  = 1'b0;
                    w_out_cnt_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StAcc;
            r_eq_acc  <= 1'b1;
            r_cnt     <= '0;
            r_out_eq  <= 1'b0;
            r_out_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_eq_acc  <= w_eq_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_out_eq  <= w_out_eq_nxt;
            r_out_cnt <= w_out_cnt_nxt;
        end
    end

`ifdef CMP_EQ_IDX_EN
    logic [CNTW-1:0] r_idx, w_idx_nxt;
    logic [CNTW-1:0] r_out_idx, w_out_idx_nxt;
    logic [CNTW-1:0] w_idx_now;

    // A cleared eq_acc already means a mismatch was seen, so r_idx is valid then.
    assign w_idx_now = !r_eq_acc ? r_idx : (w_weq ? w_cnt_inc : r_cnt);

    always_comb begin
        w_idx_nxt     = r_idx;
        w_out_idx_nxt = r_out_idx;
        unique case (r_state)
            StAcc: begin
                if (w_fire) begin
                    if (r_eq_acc && !w_weq) begin
                        w_idx_nxt = r_cnt;
                    end
                    if (bus.in_last) begin
                        w_out_idx_nxt = w_idx_now;
                    end
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    w_idx_nxt     = '0;
                    w_out_idx_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx     <= '0;
            r_out_idx <= '0;
        end else begin
            r_idx     <= w_idx_nxt;
            r_out_idx <= w_out_idx_nxt;
        end
    end

    assign bus.out_idx = r_out_idx;
`else
    assign bus.out_idx = '0;
`endif

endmodule

// File: tb/tb_au_cmp_eq_seq.sv
// Self-checking bench for au_cmp_eq_seq: directed cases then randomized throttled traffic
// scored against a per-operand reference model.
module tb_au_cmp_eq_seq;
    localparam int unsigned W     = 8;
    localparam int unsigned CW    = 3;
    localparam int          CMax  = (1 << CW) - 1;
    localparam int          NOps  = 1000;
`ifdef CMP_EQ_IDX_EN
    localparam logic [31:0] IdxMask = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] IdxMask = 32'h0;
`endif

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    au_cmp_eq_seq_if #(.WIDTH(W), .CNTW(CW)) bus ();

    au_cmp_eq_seq #(.WIDTH(W), .CNTW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] xi(input int v);
        return v & IdxMask;
    endfunction

    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        int t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("beat_timeout", (t >= 200), 0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_verdict(input string tag, input logic eq, input int cnt, input int idx);
        int t = 0;
        while (!bus.out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_timeout"}, (t >= 200), 0);
        chk({tag, "_eq"}, bus.out_eq, eq);
        chk({tag, "_cnt"}, bus.out_cnt, cnt);
        chk({tag, "_idx"}, bus.out_idx, xi(idx));
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    // Reference verdict queues for the random phase.
    logic q_eq[$];
    int   q_cnt[$];
    int   q_idx[$];

    initial begin
        #(10 * 90000);
        chk("watchdog", 1, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_eq", bus.out_eq, 0);
        chk("rst_out_cnt", bus.out_cnt, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        rst = 1'b0;
        @(posedge clk);
        #1 chk("rel_in_ready", bus.in_ready, 1);

        // 1: four equal words; verdict visible right after the last edge
        send_beat(8'h11, 8'h11, 1'b0);
        send_beat(8'h22, 8'h22, 1'b0);
        send_beat(8'h33, 8'h33, 1'b0);
        send_beat(8'h44, 8'h44, 1'b1);
        chk("t1_latency", bus.out_valid, 1);
        chk("t1_in_ready", bus.in_ready, 0);
        wait_verdict("t1", 1'b1, 4, 4);

        // 2: mismatch at beats 1 and 2
        send_beat(8'h01, 8'h01, 1'b0);
        send_beat(8'h02, 8'hF2, 1'b0);
        send_beat(8'h03, 8'h00, 1'b1);
        wait_verdict("t2", 1'b0, 3, 1);

        // 3: verdict held 5 cycles while next operand's beat is offered
        send_beat(8'h01, 8'h01, 1'b0);
        send_beat(8'h02, 8'h03, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h07;
        bus.in_b     = 8'h07;
        bus.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_stall_ready", bus.in_ready, 0);
            chk("t3_hold_valid", bus.out_valid, 1);
            chk("t3_hold_eq", bus.out_eq, 0);
            chk("t3_hold_cnt", bus.out_cnt, 2);
            chk("t3_hold_idx", bus.out_idx, xi(1));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("t3_resume_ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_verdict("t3b", 1'b1, 1, 1);

        // 4: count saturates at 2^CW-1
        for (int k = 0; k < 10; k++) send_beat(W'(k), W'(k), (k == 9));
        wait_verdict("t4", 1'b1, CMax, CMax);

        // 5: async reset mid-operand discards partial work
        send_beat(8'h10, 8'h20, 1'b0);
        send_beat(8'h30, 8'h30, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("t5_in_ready", bus.in_ready, 0);
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_out_eq", bus.out_eq, 0);
        chk("t5_out_cnt", bus.out_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        send_beat(8'h5A, 8'h5A, 1'b1);
        wait_verdict("t5", 1'b1, 1, 1);

        // 6: random throttled traffic against the model
        fork
            begin : producer
                logic [W-1:0] ra[16];
                logic [W-1:0] rb[16];
                int           n;
                int           i;
                int           first;
                for (int op = 0; op < NOps; op++) begin
                    n     = $urandom_range(16, 1);
                    first = -1;
                    for (int k = 0; k < n; k++) begin
                        ra[k] = W'($urandom);
                        rb[k] = ($urandom_range(7) == 0) ? W'($urandom) : ra[k];
                        if (first < 0 && ra[k] != rb[k]) first = k;
                    end
                    q_eq.push_back(first < 0);
                    q_cnt.push_back((n > CMax) ? CMax : n);
                    if (first < 0) q_idx.push_back((n > CMax) ? CMax : n);
                    else q_idx.push_back((first > CMax) ? CMax : first);
                    i = 0;
                    while (i < n) begin
                        @(negedge clk);
                        if ($urandom_range(3) == 0) begin
                            bus.in_valid = 1'b0;
                            bus.in_a     = W'($urandom);
                        end else begin
                            bus.in_valid = 1'b1;
                            bus.in_a     = ra[i];
                            bus.in_b     = rb[i];
                            bus.in_last  = (i == n - 1);
                            if (bus.in_ready) i++;
                        end
                    end
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            begin : consumer
                int got = 0;
                while (got < NOps) begin
                    @(negedge clk);
                    if (bus.out_valid) begin
                        chk("rnd_stall", bus.in_ready, 0);
                        if (q_eq.size() == 0) begin
                            chk("rnd_dup_verdict", 1, 0);
                            bus.out_ready = 1'b1;
                            got++;
                        end else begin
                            chk("rnd_eq", bus.out_eq, q_eq[0]);
                            chk("rnd_cnt", bus.out_cnt, q_cnt[0]);
                            chk("rnd_idx", bus.out_idx, xi(q_idx[0]));
                            bus.out_ready = ($urandom_range(2) != 0);
                            if (bus.out_ready) begin
                                void'(q_eq.pop_front());
                                void'(q_cnt.pop_front());
                                void'(q_idx.pop_front());
                                got++;
                            end
                        end
                    end else begin
                        bus.out_ready = ($urandom_range(1) == 1);
                    end
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("rnd_left_over", q_eq.size(), 0);
        chk("rnd_no_extra", bus.out_valid, 0);
        chk("rnd_idle_ready", bus.in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
